// File: rtl/burst_arb_pkg.sv
// Shared types and default sizing for the two-requester burst arbiter.
package burst_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned DATA_W_DEFAULT    = 16;
  localparam int unsigned BURST_LEN_DEFAULT = 16;
  localparam int unsigned TIMEOUT_DEFAULT   = 64;

endpackage

// File: rtl/burst_arbiter_beat_counter.sv
// Modulo-N up-counter with synchronous clear, enable and terminal-count flag.
module beat_counter #(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over enable; enabled count wraps at N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/burst_arbiter.sv
// Two-requester burst arbiter: grants fixed-length bursts downstream with
// alternating priority and an idle timeout that releases a stalled owner.
module burst_arbiter
  import burst_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req0_Request,
  input  logic [DATA_W-1:0] req0_Data,
  output logic              req0_Ack,
  input  logic              req1_Request,
  input  logic [DATA_W-1:0] req1_Data,
  output logic              req1_Ack,
  output logic              Request,
  output logic [DATA_W-1:0] sdrDataOut,
  output logic              srcId,
  input  logic              Ack,
  output logic              burstDone,
  output logic              abort
);

  arb_state_e state_q;
  logic       owner_q;
  logic       prio_q;

  logic own_req;
  logic busy;
  logic xfer;
  logic idle_en;
  logic beat_tc;
  logic idle_tc;

  // Datapath is a pass-through of the owner; Reset blanks it in the same cycle.
  assign own_req    = owner_q ? req1_Request : req0_Request;
  assign busy       = (state_q == ST_BUSY) && !Reset;
  assign Request    = busy & own_req;
  assign sdrDataOut = busy ? (owner_q ? req1_Data : req0_Data) : '0;
  assign srcId      = busy & owner_q;
  assign xfer       = Request & Ack;
  assign req0_Ack   = xfer & ~owner_q;
  assign req1_Ack   = xfer & owner_q;
  assign idle_en    = busy & ~own_req;
  assign burstDone  = xfer & beat_tc;
  assign abort      = idle_en & idle_tc;

  beat_counter #(.N(BURST_LEN)) u_beat_cnt (
    .clk   (clk),
    .rst_i (Reset),
    .clr_i (abort),
    .en_i  (xfer),
    .tc_o  (beat_tc)
  );

  beat_counter #(.N(TIMEOUT)) u_idle_cnt (
    .clk   (clk),
    .rst_i (Reset),
    .clr_i (xfer | abort),
    .en_i  (idle_en),
    .tc_o  (idle_tc)
  );

  // Grant on any request; release hands priority to the other requester.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_Request || req1_Request) begin
            state_q <= ST_BUSY;
            owner_q <= (req0_Request && req1_Request) ? prio_q : req1_Request;
          end
        end
        ST_BUSY: begin
          if (burstDone || abort) begin
            state_q <= ST_IDLE;
            prio_q  <= ~owner_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, word width of every data port.
REQ-002 Parameter BURST_LEN, default 16, words per granted burst.
REQ-003 Parameter TIMEOUT, default 64, idle cycles tolerated mid-burst before abort.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 req0_Request  input  1  requester 0 has a valid word on req0_Data.
REQ-007 req0_Data  input  DATA_W  requester 0 word.
REQ-008 req0_Ack  output  1  transfer-complete pulse to requester 0.
REQ-009 req1_Request  input  1  requester 1 has a valid word on req1_Data.
REQ-010 req1_Data  input  DATA_W  requester 1 word.
REQ-011 req1_Ack  output  1  transfer-complete pulse to requester 1.
REQ-012 Request  output  1  downstream word valid.
REQ-013 sdrDataOut  output  DATA_W  downstream word.
REQ-014 srcId  output  1  index of current owner.
REQ-015 Ack  input  1  downstream acceptance.
REQ-016 burstDone  output  1  one-cycle pulse on the last word of a completed burst.
REQ-017 abort  output  1  one-cycle pulse on timeout release.

Function
REQ-018 Word transfer: a cycle in which Request=1 and Ack=1; Ack while Request=0 is ignored.
REQ-019 States: IDLE, BUSY; owner register (1 bit), beat counter (0..BURST_LEN-1), idle counter (0..TIMEOUT-1), priority bit.
REQ-020 IDLE outputs: Request=0, sdrDataOut=0, srcId=0, both req*_Ack=0.
REQ-021 IDLE -> BUSY when any reqN_Request=1; grant registered, so Request may rise no earlier than the following cycle (1-cycle grant latency).
REQ-022 Both requesting in IDLE: grant goes to the requester named by the priority bit.
REQ-023 Single requester: grant goes to it regardless of priority.
REQ-024 BUSY: Request = owner's reqN_Request, sdrDataOut = owner's data (combinational pass-through), srcId = owner.
REQ-025 BUSY: owner's reqN_Ack = Ack & Request; non-owner Ack held 0.
REQ-026 Each transfer increments the beat counter and clears the idle counter.
REQ-027 Transfer with beat counter = BURST_LEN-1: burstDone=1 that cycle; counter wraps to 0; priority set to the non-owner; next state IDLE.
REQ-028 BUSY with owner Request=0 increments the idle counter; reaching TIMEOUT-1: abort=1, counters cleared, priority set to the non-owner, next state IDLE.
REQ-029 Owner Request low for fewer than TIMEOUT cycles then high again: burst resumes at the held beat count.
REQ-030 Non-owner requests during BUSY are held off; they are never dropped, only delayed.
REQ-031 The burst-completion cycle and the timeout cycle are mutually exclusive by construction, because completion requires Request=1.

Reset
REQ-032 Reset=1 at a clock edge: state IDLE, counters 0, owner 0, priority 0, burstDone=0, abort=0; takes precedence over every other event, including mid-burst.
REQ-033 No transfer is forwarded or acknowledged in any cycle in which Reset is sampled high.

Structure
REQ-034 Package burst_arb_pkg holds the state enum and default constants DATA_W, BURST_LEN, TIMEOUT.
REQ-035 One sub-module, beat_counter: a modulo-N up-counter with clear, enable, and a terminal-count flag, instantiated for both the beat and idle counters.

Verification
REQ-036 Reset, then requester 0 alone sends 16 words 0x1000..0x100F with Ack pulsed per word -> sdrDataOut matches, srcId=0, 16 req0_Ack pulses, burstDone on the 16th, then IDLE.
REQ-037 Both request simultaneously after reset -> requester 0 gets the first burst, requester 1 the next; srcId toggles 0 then 1; req1_Ack stays 0 during burst 0.
REQ-038 Requester 1 drops Request for 10 cycles after word 5 -> no abort; burst finishes 16 words, burstDone once.
REQ-039 Requester 0 drops Request for 64 cycles after word 3 -> abort pulse; IDLE; a pending requester 1 is granted next.
REQ-040 Reset asserted mid-burst at word 8 -> all outputs 0 the next cycle; a new request restarts at beat 0 with priority to requester 0.
REQ-041 Ack pulsed while Request=0 -> no req*_Ack pulse, beat count unchanged.
